// File: rtl/pio_cpl_tx.sv
// PIO completion transmitter: captures one completion request and emits it
// as a two-beat 3-DW Cpl/CplD TLP on a 64-bit AXI4-Stream interface.
module pio_cpl_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_compl,
    input  logic        req_compl_wd,
    input  logic [2:0]  req_tc,
    input  logic [1:0]  req_attr,
    input  logic [9:0]  req_len,
    input  logic [15:0] req_rid,
    input  logic [7:0]  req_tag,
    input  logic [3:0]  req_be,
    input  logic [6:0]  req_addr,
    input  logic [31:0] rd_data,
    input  logic [15:0] completer_id,
    output logic [63:0] tx_tdata,
    output logic [7:0]  tx_tkeep,
    output logic        tx_tlast,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        compl_done,
    output logic        cpl_busy
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t      state_q, state_d;
    logic        compl_done_q, compl_done_d;
    logic        load;

    logic        wd_q;
    logic [2:0]  tc_q;
    logic [1:0]  attr_q;
    logic [9:0]  len_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [3:0]  be_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [15:0] cid_q;

    logic [11:0] byte_cnt;
    logic [1:0]  low_addr;
    logic [31:0] dw0, dw1, dw2;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            compl_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            compl_done_q <= compl_done_d;
        end
    end

    // Clearing the captured fields on reset discards any in-flight request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q   <= 1'b0;
            tc_q   <= '0;
            attr_q <= '0;
            len_q  <= '0;
            rid_q  <= '0;
            tag_q  <= '0;
            be_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            cid_q  <= '0;
        end else if (load) begin
            wd_q   <= req_compl_wd;
            tc_q   <= req_tc;
            attr_q <= req_attr;
            len_q  <= req_len;
            rid_q  <= req_rid;
            tag_q  <= req_tag;
            be_q   <= req_be;
            addr_q <= req_addr[6:2];
            data_q <= rd_data;
            cid_q  <= completer_id;
        end
    end

    always_comb begin
        byte_cnt = 12'd1;
        casez (be_q)
            4'b1??1:                   byte_cnt = 12'd4;
            4'b01?1, 4'b1?10:          byte_cnt = 12'd3;
            4'b0011, 4'b0110, 4'b1100: byte_cnt = 12'd2;
            default:                   byte_cnt = 12'd1;
        endcase

        low_addr = 2'b00;
        if (be_q[0])      low_addr = 2'b00;
        else if (be_q[1]) low_addr = 2'b01;
        else if (be_q[2]) low_addr = 2'b10;
        else if (be_q[3]) low_addr = 2'b11;
    end

    assign dw0 = {1'b0, (wd_q ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc_q,
                  4'b0000, 2'b00, attr_q, 2'b00, len_q};
    assign dw1 = {cid_q, 3'b000, 1'b0, byte_cnt};
    assign dw2 = {rid_q, tag_q, 1'b0, addr_q, low_addr};

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        compl_done_d = 1'b0;
        tx_tvalid    = 1'b0;
        tx_tlast     = 1'b0;
        tx_tkeep     = 8'h00;
        tx_tdata     = 64'h0;
        case (state_q)
            IDLE: begin
                if (req_compl) begin
                    load    = 1'b1;
                    state_d = BEAT0;
                end
            end
            BEAT0: begin
                tx_tvalid = 1'b1;
                tx_tdata  = {dw1, dw0};
                tx_tkeep  = 8'hFF;
                if (tx_tready) state_d = BEAT1;
            end
            BEAT1: begin
                tx_tvalid = 1'b1;
                tx_tlast  = 1'b1;
                tx_tdata  = {(wd_q ? data_q : 32'h0), dw2};
                tx_tkeep  = wd_q ? 8'hFF : 8'h0F;
                if (tx_tready) begin
                    state_d      = IDLE;
                    compl_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign compl_done = compl_done_q;
    assign cpl_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_pio_cpl_tx.sv
// Self-checking bench for pio_cpl_tx: table vectors, hand-written corner
// sequences and randomized packets checked against a field-level model.
module tb_pio_cpl_tx;

    typedef struct {
        logic        wd;
        logic [2:0]  tc;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [15:0] cid;
    } req_t;

    typedef struct {
        req_t        r;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [7:0]  k1;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_compl, req_compl_wd;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [3:0]  req_be;
    logic [6:0]  req_addr;
    logic [31:0] rd_data;
    logic [15:0] completer_id;
    logic [63:0] tx_tdata;
    logic [7:0]  tx_tkeep;
    logic        tx_tlast, tx_tvalid, tx_tready;
    logic        compl_done, cpl_busy;

    int checks = 0;
    int failures = 0;

    pio_cpl_tx dut (
        .clk(clk), .rst_n(rst_n), .req_compl(req_compl), .req_compl_wd(req_compl_wd),
        .req_tc(req_tc), .req_attr(req_attr), .req_len(req_len), .req_rid(req_rid),
        .req_tag(req_tag), .req_be(req_be), .req_addr(req_addr), .rd_data(rd_data),
        .completer_id(completer_id), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
        .tx_tlast(tx_tlast), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
        .compl_done(compl_done), .cpl_busy(cpl_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic driveReq(input req_t r);
        req_compl_wd = r.wd;
        req_tc       = r.tc;
        req_attr     = r.attr;
        req_len      = r.len;
        req_rid      = r.rid;
        req_tag      = r.tag;
        req_be       = r.be;
        req_addr     = r.addr;
        rd_data      = r.data;
        completer_id = r.cid;
    endtask

    function automatic req_t randReq();
        req_t r;
        r.wd   = 1'($urandom);
        r.tc   = 3'($urandom);
        r.attr = 2'($urandom);
        r.len  = 10'($urandom);
        r.rid  = 16'($urandom);
        r.tag  = 8'($urandom);
        r.be   = 4'($urandom);
        r.addr = 7'($urandom);
        r.data = $urandom;
        r.cid  = 16'($urandom);
        return r;
    endfunction

    // Reference: byte count is the span from lowest to highest enabled byte.
    function automatic void model(input req_t r, output logic [63:0] b0,
                                  output logic [63:0] b1, output logic [7:0] k1);
        int lo, hi, bc;
        logic [31:0] dw0, dw1, dw2;
        lo = -1;
        hi = -1;
        for (int i = 0; i < 4; i++)
            if (r.be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        bc = (lo < 0) ? 1 : (hi - lo + 1);
        if (lo < 0) lo = 0;
        dw0 = (r.wd ? 32'h4000_0000 : 32'h0) + 32'h0A00_0000 + (32'(r.tc) << 20)
              + (32'(r.attr) << 12) + 32'(r.len);
        dw1 = {r.cid, 16'(bc)};
        dw2 = 32'(r.rid) * 65536 + 32'(r.tag) * 256 + 32'(r.addr & 7'h7C) + 32'(lo);
        b0 = {dw1, dw0};
        b1 = {(r.wd ? r.data : 32'h0), dw2};
        k1 = r.wd ? 8'hFF : 8'h0F;
    endfunction

    // Drives one request in the current cycle and follows the TLP cycle by
    // cycle; returns in the compl_done cycle so callers may chain requests.
    task automatic runPacket(input req_t r, input logic [63:0] eb0, input logic [63:0] eb1,
                             input logic [7:0] ek1, input int s0, input int s1,
                             input bit probe, input string nm);
        req_t junk;
        driveReq(r);
        req_compl = 1'b1;
        tx_tready = 1'b1;
        tick();
        junk = randReq();
        if (probe) junk.tag = r.tag ^ 8'h5A;
        driveReq(junk);
        for (int i = 0; i <= s0; i++) begin
            req_compl = (probe && i == 0);
            tx_tready = (i == s0);
            check({nm, " b0 valid"}, 64'(tx_tvalid), 64'd1);
            check({nm, " b0 data"},  tx_tdata, eb0);
            check({nm, " b0 keep"},  64'(tx_tkeep), 64'hFF);
            check({nm, " b0 last"},  64'(tx_tlast), 64'd0);
            check({nm, " b0 done"},  64'(compl_done), 64'd0);
            tick();
        end
        req_compl = 1'b0;
        for (int i = 0; i <= s1; i++) begin
            tx_tready = (i == s1);
            check({nm, " b1 valid"}, 64'(tx_tvalid), 64'd1);
            check({nm, " b1 data"},  tx_tdata, eb1);
            check({nm, " b1 keep"},  64'(tx_tkeep), 64'(ek1));
            check({nm, " b1 last"},  64'(tx_tlast), 64'd1);
            tick();
        end
        tx_tready = 1'b1;
        check({nm, " done pulse"}, 64'(compl_done), 64'd1);
        check({nm, " done valid"}, 64'(tx_tvalid), 64'd0);
        check({nm, " done busy"},  64'(cpl_busy), 64'd0);
    endtask

    task automatic idleCycle(input string nm);
        tick();
        check({nm, " idle done"},  64'(compl_done), 64'd0);
        check({nm, " idle valid"}, 64'(tx_tvalid), 64'd0);
    endtask

    vec_t tbl[6];
    req_t base;
    logic [63:0] mb0, mb1;
    logic [7:0]  mk1;

    initial begin
        base.wd = 1'b1; base.tc = 3'd0; base.attr = 2'd0; base.len = 10'd1;
        base.rid = 16'h0100; base.tag = 8'h05; base.be = 4'hF; base.addr = 7'h14;
        base.data = 32'hDEADBEEF; base.cid = 16'h0200;

        tbl[0].r = base;
        tbl[0].b0 = 64'h0200_0004_4A00_0001; tbl[0].b1 = 64'hDEADBEEF_0100_0514;
        tbl[0].k1 = 8'hFF; tbl[0].name = "cpld";
        tbl[1].r = base; tbl[1].r.wd = 1'b0;
        tbl[1].b0 = 64'h0200_0004_0A00_0001; tbl[1].b1 = 64'h00000000_0100_0514;
        tbl[1].k1 = 8'h0F; tbl[1].name = "cpl";
        tbl[2].r = base; tbl[2].r.be = 4'b0110;
        tbl[2].b0 = 64'h0200_0002_4A00_0001; tbl[2].b1 = 64'hDEADBEEF_0100_0515;
        tbl[2].k1 = 8'hFF; tbl[2].name = "be0110";
        tbl[3].r = base; tbl[3].r.be = 4'b1000;
        tbl[3].b0 = 64'h0200_0001_4A00_0001; tbl[3].b1 = 64'hDEADBEEF_0100_0517;
        tbl[3].k1 = 8'hFF; tbl[3].name = "be1000";
        tbl[4].r = base; tbl[4].r.be = 4'b0000;
        tbl[4].b0 = 64'h0200_0001_4A00_0001; tbl[4].b1 = 64'hDEADBEEF_0100_0514;
        tbl[4].k1 = 8'hFF; tbl[4].name = "be0000";
        tbl[5].r = base; tbl[5].r.be = 4'b1010;
        tbl[5].b0 = 64'h0200_0003_4A00_0001; tbl[5].b1 = 64'hDEADBEEF_0100_0515;
        tbl[5].k1 = 8'hFF; tbl[5].name = "be1010";

        rst_n = 1'b0;
        req_compl = 1'b0;
        tx_tready = 1'b1;
        driveReq(base);
        tick();
        tick();
        check("reset valid", 64'(tx_tvalid), 64'd0);
        check("reset last",  64'(tx_tlast), 64'd0);
        check("reset keep",  64'(tx_tkeep), 64'd0);
        check("reset data",  tx_tdata, 64'd0);
        check("reset done",  64'(compl_done), 64'd0);
        check("reset busy",  64'(cpl_busy), 64'd0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            runPacket(tbl[i].r, tbl[i].b0, tbl[i].b1, tbl[i].k1, 0, 0, 1'b0, tbl[i].name);
            idleCycle(tbl[i].name);
        end

        runPacket(tbl[0].r, tbl[0].b0, tbl[0].b1, tbl[0].k1, 3, 2, 1'b0, "backpressure");
        idleCycle("backpressure");

        runPacket(tbl[0].r, tbl[0].b0, tbl[0].b1, tbl[0].k1, 0, 0, 1'b1, "ignore");
        idleCycle("ignore");

        // Second request issued in the compl_done cycle of the first.
        runPacket(tbl[0].r, tbl[0].b0, tbl[0].b1, tbl[0].k1, 0, 0, 1'b0, "chainA");
        runPacket(tbl[1].r, tbl[1].b0, tbl[1].b1, tbl[1].k1, 0, 0, 1'b0, "chainB");
        idleCycle("chainB");

        driveReq(base);
        req_compl = 1'b1;
        tx_tready = 1'b1;
        tick();
        req_compl = 1'b0;
        check("rst beat0 valid", 64'(tx_tvalid), 64'd1);
        tick();
        check("rst beat1 last", 64'(tx_tlast), 64'd1);
        rst_n = 1'b0;
        tick();
        check("midrst valid", 64'(tx_tvalid), 64'd0);
        check("midrst data",  tx_tdata, 64'd0);
        check("midrst keep",  64'(tx_tkeep), 64'd0);
        check("midrst done",  64'(compl_done), 64'd0);
        check("midrst busy",  64'(cpl_busy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("postrst done",  64'(compl_done), 64'd0);
        check("postrst valid", 64'(tx_tvalid), 64'd0);
        runPacket(tbl[5].r, tbl[5].b0, tbl[5].b1, tbl[5].k1, 0, 1, 1'b0, "postrst");
        idleCycle("postrst");

        for (int n = 0; n < 40; n++) begin
            req_t rr;
            rr = randReq();
            model(rr, mb0, mb1, mk1);
            runPacket(rr, mb0, mb1, mk1, int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)), 1'($urandom), "random");
            if ($urandom_range(0, 1) == 1) idleCycle("random");
        end
        idleCycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
